scan_chain_controller: RTL and testbench
========================================

// Module: scan_chain_controller
// PURPOSE
//   Sequences the datapath scan chain (Test/SDI/SDO) so that a debug host can dump and reload
//   register-file and pipeline state one word at a time. Sits between the debug port and the
//   datapath. Asserts Busy to stall the control unit while a session runs.
//   Every session shifts the whole chain once: new bits go in while old bits come out.
// PARAMETERS
//   CHAIN_LEN  128  scan chain length in bits; must be a nonzero multiple of WORD_W
//   WORD_W     16   host word width = bits shifted per word
// PORTS
//   Clock     in   1       system clock; all logic on rising edge
//   Reset     in   1       synchronous, active-high reset
//   Start     in   1       1-cycle request to begin a session; ignored unless in IDLE
//   Abort     in   1       cancel the session in progress
//   InData    in   WORD_W  word to shift into the chain, LSB first
//   InValid   in   1       InData valid
//   InReady   out  1       controller accepts InData this cycle
//   OutData   out  WORD_W  word captured from SDO; first bit out sits in bit 0
//   OutValid  out  1       OutData valid
//   OutReady  in   1       host accepts OutData
//   Test      out  1       datapath scan-shift enable
//   SDI       out  1       serial data into the chain
//   SDO       in   1       serial data out of the chain
//   Busy      out  1       session active; control unit must hold all register write-enables low
//   Done      out  1       1-cycle pulse when a session completes normally
//   Aborted   out  1       1-cycle pulse when a session ends through Abort
// BEHAVIOUR
//   Reset values: state=IDLE; all outputs 0 (OutData=0, Test=0, SDI=0, Busy=0).
//   States and transitions:
//     IDLE   -> WAIT_IN on Start. Clear the word count; Busy=1 from the next cycle.
//     WAIT_IN: InReady=1. On InValid load the shift-in register and clear the bit count -> SHIFT.
//     SHIFT: Test=1 for exactly WORD_W consecutive cycles.
//       - In shift cycle k: SDI=in_reg[k], and SDO is sampled into out_reg[k] at that cycle's edge.
//       - After cycle WORD_W-1 -> PRESENT. Test drops to 0 in the following cycle.
//     PRESENT: OutValid=1 with OutData stable until OutReady.
//       - On OutValid&OutReady, if this is the last word (CHAIN_LEN/WORD_W words done) -> DONE.
//       - Otherwise increment the word count -> WAIT_IN.
//     DONE: Done=1 and Busy=0 for one cycle -> IDLE.
//   Test is high only in SHIFT. The chain never shifts while waiting on the host, so host stalls
//     are harmless.
//   SDI is held at 0 outside SHIFT.
//   Latency from InData accepted to OutValid is WORD_W+1 cycles.
//   A session takes (CHAIN_LEN/WORD_W)*(WORD_W+2) cycles minimum.
//   Word 0 out = first WORD_W bits leaving SDO. Word 0 in = first WORD_W bits entering SDI;
//     after the full session, word 0 lands at the far (SDO) end of the chain.
//   Abort:
//     - Honoured in WAIT_IN, SHIFT and PRESENT.
//     - The next state is IDLE, with Test=0, OutValid=0, InReady=0 and Aborted=1 for one cycle.
//     - Chain contents after an abort are undefined.
//   Abort has priority over InValid and over OutReady in the same cycle.
//   Start outside IDLE is ignored. Start together with Abort in IDLE is ignored.
//   Reset mid-session: the next cycle is IDLE with every output at its reset value,
//     with no Done or Aborted pulse.
//   Counters: bit count has $clog2(WORD_W) bits and word count has $clog2(CHAIN_LEN/WORD_W)+1
//     bits. Both count up and never wrap within a session.
// TESTING
//   Bench chain model: a CHAIN_LEN shift register clocked when Test=1; SDO = model[0].
//   Use CHAIN_LEN=32, WORD_W=16.
//   1. Reset: chain preload 0xDEAD_BEEF; Start; send 0x1234 then 0xA5A5 ->
//      - OutData 0xBEEF then 0xDEAD;
//      - chain = 0xA5A5_1234;
//      - Done 1 cycle after the 2nd handshake; Test high exactly 32 cycles total.
//   2. Host stalls: InValid delayed 5 cycles and OutReady delayed 7 cycles ->
//      - Test=0 throughout both stalls; OutData held stable;
//      - results identical to scenario 1.
//   3. Abort during shift cycle 8 of word 1 -> Test=0 next cycle, Aborted pulse, Busy=0, no Done;
//      then a new Start runs a full session correctly.
//   4. Reset asserted in PRESENT with OutValid=1 -> next cycle all outputs 0 and state IDLE;
//      Start is ignored while Reset is held.
//   5. Start pulsed during SHIFT, and Start+Abort together in IDLE -> both ignored; word count unchanged.
//   6. Back-to-back: Start in the cycle after Done -> second session round-trips chain 0x0000_FFFF
//      with correct word order.

Source files
------------

// File: rtl/scan_chain_controller_if.sv
// Debug-host and datapath scan signals of the scan chain controller.
// The host/bench drives the master side; the controller implements the slave side.
interface scan_chain_controller_if #(
   parameter int WORD_W = 16
);
   logic              Start;
   logic              Abort;
   logic [WORD_W-1:0] InData;
   logic              InValid;
   logic              InReady;
   logic [WORD_W-1:0] OutData;
   logic              OutValid;
   logic              OutReady;
   logic              Test;
   logic              SDI;
   logic              SDO;
   logic              Busy;
   logic              Done;
   logic              Aborted;

   modport master (
      output Start, Abort, InData, InValid, OutReady, SDO,
      input  InReady, OutData, OutValid, Test, SDI, Busy, Done, Aborted
   );

   modport slave (
      input  Start, Abort, InData, InValid, OutReady, SDO,
      output InReady, OutData, OutValid, Test, SDI, Busy, Done, Aborted
   );
endinterface

// File: rtl/scan_chain_controller.sv
// Shifts the whole scan chain one host word at a time; word out is valid WORD_W+1 cycles after word in.
// Host stalls on either handshake simply park the FSM with Test low, so the chain never moves while waiting.
module scan_chain_controller #(
   parameter int CHAIN_LEN = 128,
   parameter int WORD_W    = 16
) (
   input  logic                    Clock,
   input  logic                    Reset,
   scan_chain_controller_if.slave  bus
);
   localparam int N_WORDS = CHAIN_LEN / WORD_W;
   localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int WCNT_W  = $clog2(N_WORDS) + 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(N_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IN,
      S_SHIFT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t              state_q,    state_d;
   logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
   logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0]   in_reg_q,   in_reg_d;
   logic [WORD_W-1:0]   out_reg_q,  out_reg_d;
   logic                aborted_q,  aborted_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         in_reg_q   <= '0;
         out_reg_q  <= '0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         in_reg_q   <= in_reg_d;
         out_reg_q  <= out_reg_d;
         aborted_q  <= aborted_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      in_reg_d   = in_reg_q;
      out_reg_d  = out_reg_q;
      aborted_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start && !bus.Abort) begin
               word_cnt_d = '0;
               state_d    = S_WAIT_IN;
            end
         end
         S_WAIT_IN: begin
            if (bus.Abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (bus.InValid) begin
               in_reg_d  = bus.InData;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bus.Abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               // SDO shows the bit leaving the chain this cycle, so it pairs with index bit_cnt_q.
               out_reg_d[bit_cnt_q] = bus.SDO;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = S_PRESENT;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PRESENT: begin
            if (bus.Abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (bus.OutReady) begin
               if (word_cnt_q == WORD_LAST) begin
                  state_d = S_DONE;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  state_d    = S_WAIT_IN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.InReady  = (state_q == S_WAIT_IN);
   assign bus.Test     = (state_q == S_SHIFT);
   assign bus.SDI      = (state_q == S_SHIFT) ? in_reg_q[bit_cnt_q] : 1'b0;
   assign bus.OutValid = (state_q == S_PRESENT);
   assign bus.OutData  = out_reg_q;
   assign bus.Busy     = (state_q == S_WAIT_IN) || (state_q == S_SHIFT) || (state_q == S_PRESENT);
   assign bus.Done     = (state_q == S_DONE);
   assign bus.Aborted  = aborted_q;
endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller with a 32-bit chain of 16-bit words.
// Expected words come straight from the preloaded chain image and the words sent in.
module tb_scan_chain_controller;
   localparam int CL = 32;
   localparam int WW = 16;
   localparam int NW = CL / WW;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   scan_chain_controller_if #(.WORD_W(WW)) bus ();

   scan_chain_controller #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Datapath chain: shifts towards bit 0 while Test is high; bit 0 drives SDO.
   logic [CL-1:0] chain;
   logic          load_req;
   logic [CL-1:0] load_val;
   always @(posedge Clock) begin
      if (load_req)      chain <= load_val;
      else if (bus.Test) chain <= {bus.SDI, chain[CL-1:1]};
   end
   assign bus.SDO = chain[0];

   int test_cnt  = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;
   always @(negedge Clock) begin
      #1;
      if (bus.Test === 1'b1)    test_cnt++;
      if (bus.Done === 1'b1)    done_cnt++;
      if (bus.Aborted === 1'b1) abort_cnt++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge Clock);
   endtask

   task automatic run_session(input logic [CL-1:0] pre, input bit do_load,
                              input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                              input int in_stall, input int out_stall,
                              input int abort_word, input int reset_word,
                              input int start_shift_word);
      logic [WW-1:0] win [NW];
      logic [CL-1:0] exp_chain;
      logic [WW-1:0] held;
      int t0, d0, a0, n;
      win[0] = w0;
      win[1] = w1;
      for (int i = 0; i < NW; i++) exp_chain[i*WW +: WW] = win[i];
      if (do_load) begin
         load_val = pre;
         load_req = 1'b1;
         cyc();
         load_req = 1'b0;
      end
      t0 = test_cnt;
      d0 = done_cnt;
      a0 = abort_cnt;
      bus.Start = 1'b1;
      cyc();
      bus.Start = 1'b0;
      check("busy_after_start", 32'(bus.Busy), 32'd1);
      for (int w = 0; w < NW; w++) begin
         for (int s = 0; s < in_stall; s++) begin
            check("in_stall_test", 32'(bus.Test), 32'd0);
            cyc();
         end
         check("in_ready", 32'(bus.InReady), 32'd1);
         bus.InData  = win[w];
         bus.InValid = 1'b1;
         cyc();
         bus.InValid = 1'b0;
         bus.InData  = WW'($urandom);
         n = 1;
         while (bus.OutValid !== 1'b1 && n < 40) begin
            if (n <= WW) check("sdi_bit", 32'(bus.SDI), 32'(win[w][n-1]));
            if (w == abort_word && n == 9) begin
               check("test_before_abort", 32'(bus.Test), 32'd1);
               bus.Abort = 1'b1;
               cyc();
               bus.Abort = 1'b0;
               check("abort_test", 32'(bus.Test), 32'd0);
               check("abort_pulse", 32'(bus.Aborted), 32'd1);
               check("abort_busy", 32'(bus.Busy), 32'd0);
               check("abort_outvalid", 32'(bus.OutValid), 32'd0);
               check("abort_inready", 32'(bus.InReady), 32'd0);
               cyc();
               check("abort_pulse_end", 32'(bus.Aborted), 32'd0);
               check("abort_no_done", 32'(done_cnt - d0), 32'd0);
               check("abort_count", 32'(abort_cnt - a0), 32'd1);
               return;
            end
            bus.Start = (w == start_shift_word && n == 4);
            cyc();
            n++;
         end
         bus.Start = 1'b0;
         check("latency", 32'(n), 32'(WW + 1));
         check("out_word", 32'(bus.OutData), 32'(pre[w*WW +: WW]));
         if (w == reset_word) begin
            Reset     = 1'b1;
            bus.Start = 1'b1;
            cyc();
            check("rst_outputs", 32'({bus.Busy, bus.Test, bus.SDI, bus.OutValid,
                                      bus.InReady, bus.Done, bus.Aborted}), 32'd0);
            check("rst_outdata", 32'(bus.OutData), 32'd0);
            cyc();
            check("rst_start_ignored", 32'(bus.Busy), 32'd0);
            Reset     = 1'b0;
            bus.Start = 1'b0;
            cyc();
            check("rst_idle_busy", 32'(bus.Busy), 32'd0);
            check("rst_no_pulses", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
            return;
         end
         held = bus.OutData;
         for (int s = 0; s < out_stall; s++) begin
            cyc();
            check("out_stall_valid", 32'(bus.OutValid), 32'd1);
            check("out_stall_data", 32'(bus.OutData), 32'(held));
            check("out_stall_test", 32'(bus.Test), 32'd0);
         end
         bus.OutReady = 1'b1;
         cyc();
         bus.OutReady = 1'b0;
         if (w == NW - 1) begin
            check("done_pulse", 32'(bus.Done), 32'd1);
            check("done_busy", 32'(bus.Busy), 32'd0);
         end else begin
            check("next_inready", 32'(bus.InReady), 32'd1);
         end
      end
      cyc();
      check("done_end", 32'(bus.Done), 32'd0);
      check("idle_busy", 32'(bus.Busy), 32'd0);
      check("test_cycles", 32'(test_cnt - t0), 32'(CL));
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("no_abort", 32'(abort_cnt - a0), 32'd0);
      check("chain", chain, exp_chain);
   endtask

   logic [CL-1:0] rnd_pre;
   initial begin
      Reset        = 1'b1;
      bus.Start    = 1'b0;
      bus.Abort    = 1'b0;
      bus.InData   = '0;
      bus.InValid  = 1'b0;
      bus.OutReady = 1'b0;
      load_req     = 1'b1;
      load_val     = '0;
      repeat (3) cyc();
      check("reset_outputs", 32'({bus.Busy, bus.Test, bus.SDI, bus.OutValid,
                                  bus.InReady, bus.Done, bus.Aborted}), 32'd0);
      check("reset_outdata", 32'(bus.OutData), 32'd0);
      Reset    = 1'b0;
      load_req = 1'b0;
      cyc();
      check("idle_busy_0", 32'(bus.Busy), 32'd0);

      // Basic session, then the same with host stalls on both handshakes.
      run_session(32'hDEAD_BEEF, 1'b1, 16'h1234, 16'hA5A5, 0, 0, -1, -1, -1);
      run_session(32'hDEAD_BEEF, 1'b1, 16'h1234, 16'hA5A5, 5, 7, -1, -1, -1);

      // Abort in shift cycle 8 of word 1, then a clean session.
      run_session(32'h1357_9BDF, 1'b1, 16'h0F0F, 16'hF0F0, 0, 0, 1, -1, -1);
      run_session(32'hCAFE_F00D, 1'b1, 16'h5A5A, 16'h3C3C, 1, 2, -1, -1, -1);

      // Reset while word 0 is presented, then a clean session.
      run_session(32'h8001_7FFE, 1'b1, 16'h1111, 16'h2222, 0, 3, -1, 0, -1);
      run_session(32'h0BAD_C0DE, 1'b1, 16'h4444, 16'h8888, 0, 0, -1, -1, -1);

      // Start during SHIFT must not disturb the session.
      run_session(32'h2468_ACE0, 1'b1, 16'h9999, 16'h7777, 0, 0, -1, -1, 0);
      // Start together with Abort in IDLE is ignored.
      bus.Start = 1'b1;
      bus.Abort = 1'b1;
      cyc();
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
      check("start_abort_idle", 32'(bus.Busy), 32'd0);
      cyc();
      check("start_abort_idle2", 32'({bus.Busy, bus.Aborted, bus.InReady}), 32'd0);

      // Back-to-back: the second session reads back what the first one wrote.
      run_session(32'h7654_3210, 1'b1, 16'hFFFF, 16'h0000, 0, 0, -1, -1, -1);
      run_session(32'h0000_FFFF, 1'b0, 16'hBEAD, 16'hFACE, 0, 0, -1, -1, -1);

      for (int r = 0; r < 6; r++) begin
         rnd_pre = CL'($urandom);
         run_session(rnd_pre, 1'b1, WW'($urandom), WW'($urandom),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     (r == 3) ? int'($urandom_range(0, NW - 1)) : -1, -1,
                     (r == 4) ? 1 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1);
   end
endmodule
